// File: rtl/shift_frame_ctrl.sv
// Shift frame controller: takes a parallel tx word and shifts it out MSB
// first while shifting the serial input into the same register. The
// received word is offered on a valid/ready port, followed by a
// programmable idle gap before the next tx word is accepted.
module shift_frame_ctrl #(
  parameter int NBIT = 8,  // frame width, 2..32
  parameter int GAP  = 1   // idle cycles after a frame, 0..15
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_tx_valid,
  output logic            o_tx_ready,
  input  logic [NBIT-1:0] i_tx_data,
  output logic            o_s,
  input  logic            i_s,
  output logic            o_frame,
  output logic            o_rx_valid,
  input  logic            i_rx_ready,
  output logic [NBIT-1:0] o_rx_data,
  output logic [7:0]      o_frame_cnt
);

  // Bit counter must hold NBIT itself so it never wraps inside a frame.
  localparam int CW = $clog2(NBIT + 1);
  // Timer reload: counts GAP-1 down to 0, giving exactly GAP cycles in ST_GAP.
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE,
    ST_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [NBIT-1:0] shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      gap_q, gap_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic            s_q, s_d;
  logic            frame_q, frame_d;
  logic [NBIT-1:0] rx_data_q, rx_data_d;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    frame_cnt_d = frame_cnt_q;
    rx_data_d   = rx_data_q;

    case (state_q)
      ST_IDLE: begin
        // o_tx_ready is high in IDLE, so i_tx_valid alone is the handshake.
        if (i_tx_valid) begin
          shreg_d = i_tx_data;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d = {shreg_q[NBIT-2:0], i_s};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NBIT - 1)) begin
          state_d   = ST_DONE;
          rx_data_d = {shreg_q[NBIT-2:0], i_s};
        end
      end
      ST_DONE: begin
        if (i_rx_ready) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          if (GAP > 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Serial out and frame strobe are registered: they reflect the state
    // and register MSB that will be current in the next cycle.
    frame_d = (state_d == ST_SHIFT);
    s_d     = (state_d == ST_SHIFT) ? shreg_d[NBIT-1] : 1'b0;
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      gap_q       <= 4'd0;
      frame_cnt_q <= 8'd0;
      s_q         <= 1'b0;
      frame_q     <= 1'b0;
      rx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      frame_cnt_q <= frame_cnt_d;
      s_q         <= s_d;
      frame_q     <= frame_d;
      rx_data_q   <= rx_data_d;
    end
  end

  // Handshake flags decode the state register only; everything else is a flop.
  assign o_tx_ready  = (state_q == ST_IDLE);
  assign o_rx_valid  = (state_q == ST_DONE);
  assign o_s         = s_q;
  assign o_frame     = frame_q;
  assign o_rx_data   = rx_data_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Bench for shift_frame_ctrl (NBIT=8, GAP=1). Expected rx words are queued
// when a frame is launched and popped when the rx handshake is seen.
module tb_shift_frame_ctrl;

  localparam int NBIT = 8;
  localparam int GAP  = 1;

  logic            i_clk;
  logic            i_rst;
  logic            i_tx_valid;
  logic            o_tx_ready;
  logic [NBIT-1:0] i_tx_data;
  logic            o_s;
  logic            i_s;
  logic            o_frame;
  logic            o_rx_valid;
  logic            i_rx_ready;
  logic [NBIT-1:0] o_rx_data;
  logic [7:0]      o_frame_cnt;

  logic            loop_en;
  logic            s_drive;
  logic [7:0]      sb[$];
  int              n_cmp;
  int              n_bad;
  int              exp_cnt;

  shift_frame_ctrl #(.NBIT(NBIT), .GAP(GAP)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_tx_valid (i_tx_valid),
    .o_tx_ready (o_tx_ready),
    .i_tx_data  (i_tx_data),
    .o_s        (o_s),
    .i_s        (i_s),
    .o_frame    (o_frame),
    .o_rx_valid (o_rx_valid),
    .i_rx_ready (i_rx_ready),
    .o_rx_data  (o_rx_data),
    .o_frame_cnt(o_frame_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Loopback ties the serial input to the serial output.
  always_comb i_s = loop_en ? o_s : s_drive;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!o_tx_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("tx_ready_timeout", {31'd0, o_tx_ready}, 32'd1);
  endtask

  // Scoreboard: every rx handshake pops the oldest expected word.
  always @(negedge i_clk) begin
    if (!i_rst && o_rx_valid && i_rx_ready) begin
      if (sb.size() == 0) begin
        chk("rx_unexpected", {31'd0, o_rx_valid}, 32'd0);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        chk("rx_data", {24'd0, o_rx_data}, {24'd0, e});
        $display("rx handshake: data %02h expected %02h", o_rx_data, e);
      end
    end
  end

  // One full frame: launch, check serial stream, optional backpressure,
  // handshake, gap, return to idle.
  task automatic do_frame(input logic [7:0] word, input bit loop, input logic [7:0] pat, input int bp);
    logic [7:0] exp_rx;
    exp_rx = loop ? word : pat;
    wait_ready();
    loop_en    = loop;
    i_rx_ready = (bp == 0);
    i_tx_data  = word;
    i_tx_valid = 1'b1;
    sb.push_back(exp_rx);
    tick();
    i_tx_valid = 1'b0;
    for (int i = 0; i < NBIT; i++) begin
      if (!loop) s_drive = pat[7-i];
      chk("frame_hi", {31'd0, o_frame}, 32'd1);
      chk("s_bit", {31'd0, o_s}, loop ? {31'd0, word[7-i]} : 32'd0);
      chk("tx_ready_busy", {31'd0, o_tx_ready}, 32'd0);
      tick();
    end
    chk("frame_end", {31'd0, o_frame}, 32'd0);
    chk("rx_valid_first", {31'd0, o_rx_valid}, 32'd1);
    for (int j = 0; j < bp; j++) begin
      chk("bp_valid", {31'd0, o_rx_valid}, 32'd1);
      chk("bp_data", {24'd0, o_rx_data}, {24'd0, exp_rx});
      chk("bp_tx_ready", {31'd0, o_tx_ready}, 32'd0);
      tick();
    end
    i_rx_ready = 1'b1;
    tick();
    exp_cnt = (exp_cnt + 1) % 256;
    chk("rx_valid_drop", {31'd0, o_rx_valid}, 32'd0);
    chk("gap_tx_ready", {31'd0, o_tx_ready}, 32'd0);
    chk("frame_cnt", {24'd0, o_frame_cnt}, exp_cnt);
    tick();
    chk("idle_tx_ready", {31'd0, o_tx_ready}, 32'd1);
    $display("frame tx %02h loop %0d bp %0d -> cnt %0d", word, loop, bp, o_frame_cnt);
  endtask

  initial begin
    logic [7:0] w1;
    logic [7:0] w2;
    int n;
    n_cmp      = 0;
    n_bad      = 0;
    exp_cnt    = 0;
    loop_en    = 1'b1;
    s_drive    = 1'b0;
    i_tx_valid = 1'b0;
    i_tx_data  = '0;
    i_rx_ready = 1'b1;
    i_rst      = 1'b1;
    #1;
    chk("rst_tx_ready", {31'd0, o_tx_ready}, 32'd1);
    chk("rst_s", {31'd0, o_s}, 32'd0);
    chk("rst_frame", {31'd0, o_frame}, 32'd0);
    chk("rst_rx_valid", {31'd0, o_rx_valid}, 32'd0);
    chk("rst_rx_data", {24'd0, o_rx_data}, 32'd0);
    chk("rst_cnt", {24'd0, o_frame_cnt}, 32'd0);
    tick();
    tick();
    i_rst = 1'b0;

    // Loopback, independent serial in, backpressure.
    do_frame(8'hA5, 1'b1, 8'h00, 0);
    do_frame(8'h00, 1'b0, 8'hCC, 0);
    do_frame(8'h69, 1'b1, 8'h00, 5);

    // Back-to-back with i_tx_valid held high.
    w1 = 8'h3C;
    w2 = 8'hC3;
    wait_ready();
    loop_en    = 1'b1;
    i_rx_ready = 1'b1;
    i_tx_data  = w1;
    i_tx_valid = 1'b1;
    sb.push_back(w1);
    tick();
    i_tx_data = w2;
    sb.push_back(w2);
    for (int i = 0; i < NBIT; i++) begin
      chk("b2b_s1", {31'd0, o_s}, {31'd0, w1[7-i]});
      tick();
    end
    chk("b2b_valid1", {31'd0, o_rx_valid}, 32'd1);
    tick();
    n = 0;
    while (!o_frame && n < 10) begin
      tick();
      n++;
    end
    chk("b2b_spacing", n, 32'd2);
    i_tx_valid = 1'b0;
    for (int i = 0; i < NBIT; i++) begin
      chk("b2b_s2", {31'd0, o_s}, {31'd0, w2[7-i]});
      tick();
    end
    chk("b2b_valid2", {31'd0, o_rx_valid}, 32'd1);
    tick();
    chk("b2b_gap", {31'd0, o_tx_ready}, 32'd0);
    tick();
    chk("b2b_idle", {31'd0, o_tx_ready}, 32'd1);
    chk("b2b_no_extra", {31'd0, o_frame}, 32'd0);
    exp_cnt = exp_cnt + 2;
    chk("b2b_cnt", {24'd0, o_frame_cnt}, exp_cnt);
    $display("back-to-back %02h %02h spacing %0d cnt %0d", w1, w2, n, o_frame_cnt);

    // Reset in the middle of a frame.
    wait_ready();
    loop_en    = 1'b1;
    i_tx_data  = 8'h5A;
    i_tx_valid = 1'b1;
    sb.push_back(8'h5A);
    tick();
    i_tx_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2;
    i_rst = 1'b1;
    #1;
    sb.delete();
    exp_cnt = 0;
    chk("mid_rst_frame", {31'd0, o_frame}, 32'd0);
    chk("mid_rst_s", {31'd0, o_s}, 32'd0);
    chk("mid_rst_tx_ready", {31'd0, o_tx_ready}, 32'd1);
    chk("mid_rst_rx_valid", {31'd0, o_rx_valid}, 32'd0);
    chk("mid_rst_rx_data", {24'd0, o_rx_data}, 32'd0);
    chk("mid_rst_cnt", {24'd0, o_frame_cnt}, 32'd0);
    $display("mid-frame reset: frame %0d cnt %0d", o_frame, o_frame_cnt);
    tick();
    i_rst = 1'b0;
    tick();
    chk("post_rst_idle", {31'd0, o_frame}, 32'd0);
    do_frame(8'h96, 1'b1, 8'h00, 0);

    // Frame counter wrap.
    for (int k = 0; k < 256; k++) begin
      do_frame(8'(k * 37 + 11), 1'b1, 8'h00, 0);
      if (exp_cnt == 0) chk("cnt_wrap_zero", {24'd0, o_frame_cnt}, 32'd0);
    end
    chk("cnt_after_wrap", {24'd0, o_frame_cnt}, 32'd1);

    tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_frame_ctrl.md
SHIFT_FRAME_CTRL -- requirements
Module: shift_frame_ctrl

Interface
REQ-001 SHALL have parameter NBIT, default 8: frame width in bits; legal range 2..32.
REQ-002 SHALL have parameter GAP, default 1: idle cycles between frame completion and the next tx accept; legal range 0..15.
REQ-003 SHALL have port i_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port i_tx_valid, input, 1: parallel tx word offered.
REQ-006 SHALL have port o_tx_ready, output, 1: controller can accept a tx word.
REQ-007 SHALL have port i_tx_data, input, NBIT: parallel word to serialize.
REQ-008 SHALL have port o_s, output, 1: serial out, MSB first.
REQ-009 SHALL have port i_s, input, 1: serial in, sampled during the frame.
REQ-010 SHALL have port o_frame, output, 1: high exactly during shift cycles.
REQ-011 SHALL have port o_rx_valid, output, 1: received word available.
REQ-012 SHALL have port i_rx_ready, input, 1: consumer accepts the rx word.
REQ-013 SHALL have port o_rx_data, output, NBIT: received parallel word.
REQ-014 SHALL have port o_frame_cnt, output, 8: count of completed frames, wraps 255->0.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE, GAP.
REQ-016 SHALL drive o_tx_ready high only in IDLE.
REQ-017 SHALL, in IDLE on i_tx_valid&&o_tx_ready: load the internal NBIT shift register with i_tx_data, clear the bit counter, and go to SHIFT.
REQ-018 SHALL, in SHIFT: drive o_s = shreg[NBIT-1], set o_frame=1, and each edge update shreg <= {shreg[NBIT-2:0], i_s} and increment the counter.
REQ-019 SHALL leave SHIFT after exactly NBIT shift edges and enter DONE; the counter is $clog2(NBIT+1) bits and never wraps inside a frame.
REQ-020 SHALL, in DONE: hold o_rx_valid=1 and o_rx_data=shreg stable until i_rx_ready is sampled high.
REQ-021 SHALL, on the DONE handshake edge, increment o_frame_cnt and go to GAP if GAP>0, else to IDLE.
REQ-022 SHALL stay in GAP for exactly GAP cycles, then go to IDLE.
REQ-023 SHALL have a latency such that, with accept at edge k, frame cycles are k+1..k+NBIT and o_rx_valid is first high in the cycle after edge k+NBIT.
REQ-024 SHALL place the first-sampled i_s bit at o_rx_data[NBIT-1] and the last at bit 0, so that loopback (i_s=o_s) returns the tx word unchanged.
REQ-025 SHALL ignore i_tx_valid outside IDLE, with no tx word queued or lost-accepted.
REQ-026 SHALL drive o_s=0 and o_frame=0 outside SHIFT, and o_rx_valid=0 outside DONE.
REQ-027 SHALL, when i_rx_ready is held high before DONE, complete the handshake in the first DONE cycle (o_rx_valid high for one cycle).
REQ-028 SHALL use only registered outputs, except o_tx_ready and o_rx_valid, which are decoded from the state register only, with no input-to-output combinational path.

Reset
REQ-029 SHALL, on i_rst assertion, immediately go to IDLE and clear shreg, the counter, GAP timer and o_frame_cnt, giving o_tx_ready=1, o_s=0, o_frame=0, o_rx_valid=0, o_rx_data=0 and o_frame_cnt=0.
REQ-030 SHALL abort a frame in progress on reset mid-SHIFT/DONE/GAP, with no o_rx_valid pulse and no o_frame_cnt increment.
REQ-031 SHALL accept the first tx word no earlier than the first rising edge after i_rst deasserts.

Verification (NBIT=8, GAP=1)
REQ-032 SHALL cover loopback: i_s=o_s, tx 0xA5, rx_ready=1 -> o_s sequence 1,0,1,0,0,1,0,1; o_frame high 8 cycles; o_rx_data=0xA5; o_frame_cnt=1.
REQ-033 SHALL cover independent serial in: tx 0x00, i_s driven 1,1,0,0,1,1,0,0 -> o_rx_data=0xCC and o_s=0 throughout.
REQ-034 SHALL cover rx backpressure: i_rx_ready low 5 cycles in DONE -> o_rx_valid and o_rx_data stable for 5 cycles, o_tx_ready=0, then exactly 1 GAP cycle before o_tx_ready=1.
REQ-035 SHALL cover back-to-back: i_tx_valid held high with 0x3C then 0xC3 -> second accept exactly 2 cycles after first rx handshake (DONE, GAP); both words looped back correctly.
REQ-036 SHALL cover reset mid-frame: i_rst pulsed after 4 shift cycles -> outputs at reset values asynchronously, no o_rx_valid, o_frame_cnt=0, next frame correct.
REQ-037 SHALL cover counter wrap: 256 loopback frames -> o_frame_cnt wraps to 0.
